// File: rtl/mem_copy_engine.sv
// mem_copy_engine: DMA-style word copier for the 16-bit, byte-addressable,
// single-cycle data memory. Each word is moved with one read cycle and then
// one write cycle, because the memory cannot read and write at once.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   start, src, dst, len     copy command; only sampled while idle
//   busy, done, words_done   status; done is a one-cycle completion pulse
//   mem_enable, mem_wr,      memory request port, decoded from registered
//   mem_addr, mem_data_in    state only (no path from the command inputs)
//   mem_data_out             combinational read data returned by the memory
module mem_copy_engine #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      src,
  input  logic [15:0]      dst,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_enable,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]  dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   words_done_q, words_done_d;
  logic [DATA_W-1:0]  rd_buf_q, rd_buf_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length command skips straight to DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (len != '0) ? S_READ : S_DONE;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = (remaining_q == LEN_W'(1)) ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state and pointers
  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    mem_enable  = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    unique case (state_q)
      S_READ: begin
        mem_enable = 1'b1;
        mem_addr   = src_ptr_q;
      end
      S_WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dst_ptr_q;
        mem_data_in = rd_buf_q;
      end
      default: ;
    endcase
  end

  assign words_done = words_done_q;

  // Datapath next values: command latch, read capture, pointer advance
  always_comb begin
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    remaining_d  = remaining_q;
    words_done_d = words_done_q;
    rd_buf_d     = rd_buf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          words_done_d = '0;
          if (len != '0) begin
            src_ptr_d   = src;
            dst_ptr_d   = dst;
            remaining_d = len;
          end
        end
      end
      // Read data is combinational, so it is captured at the edge ending READ
      S_READ: rd_buf_d = mem_data_out;
      S_WRITE: begin
        // Pointers wrap modulo 2^16 by truncation
        src_ptr_d    = ADDR_W'(src_ptr_q + ADDR_W'(2));
        dst_ptr_d    = ADDR_W'(dst_ptr_q + ADDR_W'(2));
        remaining_d  = LEN_W'(remaining_q - LEN_W'(1));
        words_done_d = LEN_W'(words_done_q + LEN_W'(1));
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      remaining_q  <= '0;
      words_done_q <= '0;
      rd_buf_q     <= '0;
    end else begin
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      remaining_q  <= remaining_d;
      words_done_q <= words_done_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: byte-addressable memory model, reference
// copy model feeding an expected-transaction queue, per-scenario tasks.
module tb_mem_copy_engine;

  localparam int unsigned LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, done;
  logic [LEN_W-1:0] words_done;
  logic             mem_enable, mem_wr;
  logic [15:0]      mem_addr, mem_data_in, mem_data_out;

  logic             pl_en;
  logic [15:0]      pl_addr, pl_data;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  cyc;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .words_done   (words_done),
    .mem_enable   (mem_enable),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Memory model: combinational read, big-endian byte pair, wrapping addr+1
  assign mem_data_out = {mem[mem_addr], mem[16'(mem_addr + 16'd1)]};

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr]                 <= pl_data[15:8];
      mem[16'(pl_addr + 16'd1)]    <= pl_data[7:0];
    end else if (mem_enable && mem_wr) begin
      mem[mem_addr]                <= mem_data_in[15:8];
      mem[16'(mem_addr + 16'd1)]   <= mem_data_in[7:0];
    end
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {mem[a], mem[16'(a + 16'd1)]};
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    return {ref_mem[a], ref_mem[16'(a + 16'd1)]};
  endfunction

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d[15:8];
    ref_mem[16'(a + 16'd1)] = d[7:0];
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // Reference forward copy of the first 'limit' words; queues expected bus
  // transactions with their cycle numbers relative to the command edge.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d,
                            input int limit, input int base);
    for (int k = 0; k < limit; k++) begin
      logic [15:0] sa, da, w;
      sa = 16'(s + 16'(2 * k));
      da = 16'(d + 16'(2 * k));
      w  = ref_word(sa);
      exp_q.push_back('{wr: 1'b0, addr: sa, data: 16'h0, cyc: 8'(base + 2 * k + 1)});
      exp_q.push_back('{wr: 1'b1, addr: da, data: w,     cyc: 8'(base + 2 * k + 2)});
      ref_mem[da] = w[15:8];
      ref_mem[16'(da + 16'd1)] = w[7:0];
    end
  endtask

  // Command accepted at the next posedge (edge 0); returns inside cycle 1
  task automatic issue(input logic [15:0] s, input logic [15:0] d,
                       input logic [LEN_W-1:0] n);
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = n;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, mem_enable, mem_wr} !== 4'b0 || words_done !== '0 ||
        mem_addr !== 16'h0 || mem_data_in !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b wd=%0d en=%b wr=%b addr=%h din=%h, required all 0",
               busy, done, words_done, mem_enable, mem_wr, mem_addr, mem_data_in);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || mem_enable !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: cycle %0d busy=%b en=%b done=%b, required 0", c, busy, mem_enable, done);
      end
    end
  endtask

  // Basic copy, address wrap and overlapping forward copy
  task automatic test_copy_patterns();
    logic [15:0] t_src [3];
    logic [15:0] t_dst [3];
    int          t_len [3];
    t_src = '{16'h0010, 16'hFFFC, 16'h0000};
    t_dst = '{16'h0020, 16'h0030, 16'h0002};
    t_len = '{4, 3, 2};
    for (int i = 0; i < 3; i++) begin
      int n;
      n = t_len[i];
      case (i)
        0: begin
          preload(16'h0010, 16'hA1B2); preload(16'h0012, 16'hC3D4);
          preload(16'h0014, 16'hE5F6); preload(16'h0016, 16'h0718);
          for (int k = 0; k < 4; k++) preload(16'(16'h0020 + 16'(2 * k)), 16'h0000);
        end
        1: begin
          preload(16'hFFFC, 16'h1234); preload(16'hFFFE, 16'h5678);
          preload(16'h0000, 16'h9ABC);
          for (int k = 0; k < 3; k++) preload(16'(16'h0030 + 16'(2 * k)), 16'h0000);
        end
        default: begin
          preload(16'h0000, 16'h1111); preload(16'h0002, 16'h2222);
          preload(16'h0004, 16'h3333);
        end
      endcase
      model_copy(t_src[i], t_dst[i], n, 0);
      issue(t_src[i], t_dst[i], LEN_W'(n));
      for (int c = 1; c <= 2 * n + 3; c++) begin
        @(negedge clk);
        if (mem_enable) begin
          txn_t e;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL copy%0d_extra_txn: cycle %0d wr=%b addr=%h, required no access", i, c, mem_wr, mem_addr);
          end else begin
            e = exp_q.pop_front();
            if (mem_wr !== e.wr || mem_addr !== e.addr || c != int'(e.cyc) ||
                (e.wr && mem_data_in !== e.data)) begin
              n_fail++;
              $display("FAIL copy%0d_txn: cycle %0d wr=%b addr=%h din=%h, required cycle %0d wr=%b addr=%h din=%h",
                       i, c, mem_wr, mem_addr, mem_data_in, e.cyc, e.wr, e.addr, e.data);
            end
          end
        end
        n_checks++;
        if (done !== (c == 2 * n + 1) || busy !== (c <= 2 * n + 1)) begin
          n_fail++;
          $display("FAIL copy%0d_status: cycle %0d done=%b busy=%b, required done=%b busy=%b",
                   i, c, done, busy, (c == 2 * n + 1), (c <= 2 * n + 1));
        end
      end
      n_checks++;
      if (exp_q.size() != 0 || words_done !== LEN_W'(n)) begin
        n_fail++;
        $display("FAIL copy%0d_final: pending=%0d words_done=%0d, required pending=0 words_done=%0d",
                 i, exp_q.size(), words_done, n);
        exp_q.delete();
      end
      for (int k = 0; k < n; k++) begin
        logic [15:0] sa, da;
        sa = 16'(t_src[i] + 16'(2 * k));
        da = 16'(t_dst[i] + 16'(2 * k));
        n_checks++;
        if (mem_word(sa) !== ref_word(sa) || mem_word(da) !== ref_word(da)) begin
          n_fail++;
          $display("FAIL copy%0d_mem: word %0d src=%h dst=%h, required src=%h dst=%h",
                   i, k, mem_word(sa), mem_word(da), ref_word(sa), ref_word(da));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    issue(16'h0040, 16'h0050, '0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (mem_enable !== 1'b0 || done !== (c == 1) || busy !== (c == 1)) begin
        n_fail++;
        $display("FAIL zero_len: cycle %0d en=%b done=%b busy=%b, required en=0 done=%b busy=%b",
                 c, mem_enable, done, busy, (c == 1), (c == 1));
      end
    end
    n_checks++;
    if (words_done !== '0) begin
      n_fail++;
      $display("FAIL zero_len_words: words_done=%0d, required 0", words_done);
    end
  endtask

  // Ignored start while busy, then reset in the WRITE of word 2
  task automatic test_abort();
    for (int k = 0; k < 8; k++) begin
      preload(16'(16'h0100 + 16'(2 * k)), 16'(16'h1000 + 16'(k * 16'h0111)));
      preload(16'(16'h0200 + 16'(2 * k)), 16'h0000);
    end
    model_copy(16'h0100, 16'h0200, 3, 0);
    issue(16'h0100, 16'h0200, LEN_W'(8));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        txn_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL abort_extra_txn: cycle %0d wr=%b addr=%h, required no access", c, mem_wr, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_wr !== e.wr || mem_addr !== e.addr || c != int'(e.cyc) ||
              (e.wr && mem_data_in !== e.data)) begin
            n_fail++;
            $display("FAIL abort_txn: cycle %0d wr=%b addr=%h din=%h, required cycle %0d wr=%b addr=%h din=%h",
                     c, mem_wr, mem_addr, mem_data_in, e.cyc, e.wr, e.addr, e.data);
          end
        end
      end
      n_checks++;
      if (done !== 1'b0 || (c >= 7 && busy !== 1'b0) || (c < 7 && busy !== 1'b1)) begin
        n_fail++;
        $display("FAIL abort_status: cycle %0d done=%b busy=%b, required done=0 busy=%b", c, done, busy, (c < 7));
      end
      if (c == 4) begin
        start = 1'b1; src = 16'h0500; dst = 16'h0600; len = LEN_W'(2);
      end
      if (c == 5) start = 1'b0;
      if (c == 6) rst = 1'b1;
      if (c == 7) rst = 1'b0;
    end
    n_checks++;
    if (exp_q.size() != 0 || words_done !== '0) begin
      n_fail++;
      $display("FAIL abort_final: pending=%0d words_done=%0d, required pending=0 words_done=0",
               exp_q.size(), words_done);
      exp_q.delete();
    end
    for (int k = 0; k < 8; k++) begin
      logic [15:0] da;
      da = 16'(16'h0200 + 16'(2 * k));
      n_checks++;
      if (mem_word(da) !== ref_word(da)) begin
        n_fail++;
        $display("FAIL abort_mem: word %0d dst=%h, required %h", k, mem_word(da), ref_word(da));
      end
    end
  endtask

  // Fresh len=1 command, then a second one accepted at the earliest edge
  task automatic test_back_to_back();
    preload(16'h0300, 16'hBEEF); preload(16'h0302, 16'hCAFE);
    preload(16'h0310, 16'h0000); preload(16'h0312, 16'h0000);
    model_copy(16'h0300, 16'h0310, 1, 0);
    model_copy(16'h0302, 16'h0312, 1, 4);
    issue(16'h0300, 16'h0310, LEN_W'(1));
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_enable) begin
        txn_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_txn: cycle %0d wr=%b addr=%h, required no access", c, mem_wr, mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (mem_wr !== e.wr || mem_addr !== e.addr || c != int'(e.cyc) ||
              (e.wr && mem_data_in !== e.data)) begin
            n_fail++;
            $display("FAIL b2b_txn: cycle %0d wr=%b addr=%h din=%h, required cycle %0d wr=%b addr=%h din=%h",
                     c, mem_wr, mem_addr, mem_data_in, e.cyc, e.wr, e.addr, e.data);
          end
        end
      end
      n_checks++;
      if (done !== (c == 3 || c == 7) || busy !== ((c >= 1 && c <= 3) || (c >= 5 && c <= 7))) begin
        n_fail++;
        $display("FAIL b2b_status: cycle %0d done=%b busy=%b, required done=%b busy=%b", c, done, busy,
                 (c == 3 || c == 7), ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      end
      if (c == 3) begin
        start = 1'b1; src = 16'h0302; dst = 16'h0312; len = LEN_W'(1);
      end
      if (c == 5) start = 1'b0;
    end
    n_checks++;
    if (exp_q.size() != 0 || words_done !== LEN_W'(1) ||
        mem_word(16'h0310) !== 16'hBEEF || mem_word(16'h0312) !== 16'hCAFE) begin
      n_fail++;
      $display("FAIL b2b_final: pending=%0d words_done=%0d m310=%h m312=%h, required 0 1 beef cafe",
               exp_q.size(), words_done, mem_word(16'h0310), mem_word(16'h0312));
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_copy_patterns();
    test_zero_len();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
